pipelined_barrel_shifter: RTL and testbench
===========================================

Name: pipelined_barrel_shifter

Overview:
- Parametrised, pipelined successor to the combinational 8-bit barrel shifter.
- Supports five shift modes: logical left, logical right, arithmetic right, rotate left, rotate right.
- Uses one register stage per shift-amount bit and valid/ready handshakes on input and output.
- Sits between a producer (ALU/datapath front end) and a consumer that may apply backpressure.

Parameters:
- WIDTH, 8, data width in bits; must be a power of 2 and at least 2.
- SHW, $clog2(WIDTH), shift-amount width; derived localparam, not overridable.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  producer has a valid operation.
- in_ready  output  1  block accepts the operation this cycle.
- in_data  input  WIDTH  operand.
- in_amt  input  SHW  shift amount, 0..WIDTH-1.
- in_mode  input  3  0 SLL, 1 SRL, 2 SRA, 3 ROL, 4 ROR, 5-7 pass-through.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- out_data  output  WIDTH  shifted result.

Behaviour:
- One clock domain; rst is asynchronous and active-high.
- Reset clears all stage valid bits, stage data/amt/mode registers and out_data to 0. After reset: out_valid=0, in_ready=1.
- Pipeline has SHW stages. Stage k (k=0..SHW-1, LSB first) shifts its input by 2^k when amt bit k is set, else passes through. Mode and amt travel with the data.
- Latency is exactly SHW cycles from accept (in_valid & in_ready) to out_valid, when there is no backpressure. For WIDTH=8 this is 3.
- Global enable: en = !(out_valid & !out_ready).
  - in_ready = en.
  - When en=1, all stages advance together and bubbles advance as bubbles.
  - When en=0, every stage holds its contents; out_data and out_valid are stable.
- Throughput: one operation per cycle when out_ready is held high.
- Mode arithmetic, each stage:
  - SLL: zero fill on the right.
  - SRL: zero fill on the left.
  - SRA: fill with the original MSB. The stage input MSB is used; it is preserved across stages because earlier stages replicate it.
  - ROL/ROR: bits leaving one end re-enter at the other.
  - Pass-through modes ignore amt.
- Boundary conditions:
  - amt=0 gives out_data=in_data for every mode.
  - in_data is sampled only on accept; changes while in_ready=0 are ignored.
  - A result is consumed exactly once, on the cycle out_valid & out_ready.
  - rst asserted mid-operation discards all in-flight operations immediately (asynchronously). No spurious out_valid is produced after release.
  - in_valid=0 with en=1 inserts a bubble (stage valid=0).
- No combinational path from in_valid/in_data to out_*. There is one combinational path from out_ready to in_ready.

Decomposition:
- Package barrel_pkg:
  - Mode constants MODE_SLL=3'd0, MODE_SRL=3'd1, MODE_SRA=3'd2, MODE_ROL=3'd3, MODE_ROR=3'd4.
- Sub-module barrel_stage, instantiated SHW times via generate.
  - Parameters: WIDTH, SHIFT (=2^k).
  - Contents: combinational shift of one stage plus its registered valid/data/amt/mode, gated by en.
- The top level holds en/handshake logic only.

Test Plan:
- WIDTH=8, in_data=8'b10010111, in_amt=3, modes SLL/SRL/SRA, out_ready=1.
  - Expected out_data 8'b10111000, 8'b00010010, 8'b11110010 on consecutive cycles, each 3 cycles after accept.
- in_data=8'b10010111 ROL amt=5 -> 8'b11110010.
- in_data=8'b01101011 ROR amt=2 -> 8'b11011010.
- amt=0 in all five modes, plus mode 6 with amt=5 -> out_data equals in_data in every case.
- Backpressure case:
  - Issue 5 back-to-back ops, holding out_ready=0 from cycle 4 to cycle 8.
  - in_ready drops with out_valid & !out_ready.
  - First result is held stable.
  - All 5 results appear in order, none lost or duplicated.
- Reset mid-flight case:
  - Accept 2 ops, then pulse rst for 1 cycle while both are in flight.
  - out_valid stays 0 for 5 cycles after release; in_ready=1.
  - A new op then completes with 3-cycle latency.
- Throughput:
  - 16 random ops with out_ready=1 produce 16 results on 16 consecutive cycles.
  - Each result matches a reference model.

Source files
------------

// File: rtl/barrel_pkg.sv
// Shared definitions for the pipelined barrel shifter: shift-mode encodings.
package barrel_pkg;

  localparam logic [2:0] MODE_SLL = 3'd0;
  localparam logic [2:0] MODE_SRL = 3'd1;
  localparam logic [2:0] MODE_SRA = 3'd2;
  localparam logic [2:0] MODE_ROL = 3'd3;
  localparam logic [2:0] MODE_ROR = 3'd4;

endpackage

// File: rtl/barrel_stage.sv
// One pipeline stage of the barrel shifter. Conditionally shifts its input
// by SHIFT positions and registers the result together with valid/amt/mode.
// All registers hold when en is low.
module barrel_stage
  import barrel_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SHIFT = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic                       shift_en,
  input  logic                       src_valid,
  input  logic [WIDTH-1:0]           src_data,
  input  logic [$clog2(WIDTH)-1:0]   src_amt,
  input  logic [2:0]                 src_mode,
  output logic                       valid,
  output logic [WIDTH-1:0]           data,
  output logic [$clog2(WIDTH)-1:0]   amt,
  output logic [2:0]                 mode
);

  localparam int SHW = $clog2(WIDTH);

  logic [WIDTH-1:0] shifted_s;
  logic             valid_r;
  logic [WIDTH-1:0] data_r;
  logic [SHW-1:0]   amt_r;
  logic [2:0]       mode_r;

  // Shift by this stage's fixed distance when its amount bit is set.
  // For SRA the stage input MSB is the original sign, since earlier
  // stages have already replicated it.
  always_comb begin
    shifted_s = src_data;
    if (shift_en) begin
      case (src_mode)
        MODE_SLL: shifted_s = {src_data[WIDTH-1-SHIFT:0], {SHIFT{1'b0}}};
        MODE_SRL: shifted_s = {{SHIFT{1'b0}}, src_data[WIDTH-1:SHIFT]};
        MODE_SRA: shifted_s = {{SHIFT{src_data[WIDTH-1]}}, src_data[WIDTH-1:SHIFT]};
        MODE_ROL: shifted_s = {src_data[WIDTH-1-SHIFT:0], src_data[WIDTH-1:WIDTH-SHIFT]};
        MODE_ROR: shifted_s = {src_data[SHIFT-1:0], src_data[WIDTH-1:SHIFT]};
        default:  shifted_s = src_data;
      endcase
    end else begin
      shifted_s = src_data;
    end
  end

  // Stage register: advances only on the global enable, cleared by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_r <= 1'b0;
      data_r  <= {WIDTH{1'b0}};
      amt_r   <= {SHW{1'b0}};
      mode_r  <= 3'd0;
    end else if (en) begin
      valid_r <= src_valid;
      data_r  <= shifted_s;
      amt_r   <= src_amt;
      mode_r  <= src_mode;
    end
  end

  assign valid = valid_r;
  assign data  = data_r;
  assign amt   = amt_r;
  assign mode  = mode_r;

endmodule

// File: rtl/pipelined_barrel_shifter.sv
// Pipelined barrel shifter: one register stage per shift-amount bit (LSB
// first) with valid/ready handshakes. A single global enable stalls the
// whole pipe when the output holds an unconsumed result.
module pipelined_barrel_shifter
  import barrel_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_amt,
  input  logic [2:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  // Index 0 is the pipe input; index k+1 is the output of stage k.
  logic             valid_s [0:SHW];
  logic [WIDTH-1:0] data_s  [0:SHW];
  logic [SHW-1:0]   amt_s   [0:SHW];
  logic [2:0]       mode_s  [0:SHW];
  logic             en_s;
  logic             unused_tail_s;

  // Global enable: stall everything while a result waits for the consumer.
  always_comb begin
    if (out_valid && !out_ready) begin
      en_s = 1'b0;
    end else begin
      en_s = 1'b1;
    end
  end

  assign in_ready   = en_s;

  assign valid_s[0] = in_valid;
  assign data_s[0]  = in_data;
  assign amt_s[0]   = in_amt;
  assign mode_s[0]  = in_mode;

  for (genvar k = 0; k < SHW; k++) begin : g_stage
    barrel_stage #(
      .WIDTH (WIDTH),
      .SHIFT (1 << k)
    ) u_stage (
      .clk       (clk),
      .rst       (rst),
      .en        (en_s),
      .shift_en  (amt_s[k][k]),
      .src_valid (valid_s[k]),
      .src_data  (data_s[k]),
      .src_amt   (amt_s[k]),
      .src_mode  (mode_s[k]),
      .valid     (valid_s[k+1]),
      .data      (data_s[k+1]),
      .amt       (amt_s[k+1]),
      .mode      (mode_s[k+1])
    );
  end

  assign out_valid = valid_s[SHW];
  assign out_data  = data_s[SHW];

  // The last stage's amount/mode have no consumer.
  assign unused_tail_s = ^{amt_s[SHW], mode_s[SHW]};

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Directed self-checking bench for pipelined_barrel_shifter (WIDTH=8).
module tb_pipelined_barrel_shifter;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic [2:0] in_amt;
  logic [2:0] in_mode;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [7:0] got_q [$];
  int         got_cyc [$];

  pipelined_barrel_shifter #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_amt    (in_amt),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every consumed result and the cycle it was consumed in.
  always @(posedge clk) begin
    if (!rst && out_valid && out_ready) begin
      got_q.push_back(out_data);
      got_cyc.push_back(cyc);
    end
  end

  // Bit-at-a-time reference shifter.
  function automatic logic [7:0] ref_shift(input logic [7:0] d, input logic [2:0] a, input logic [2:0] m);
    logic [7:0] r;
    r = d;
    for (int i = 0; i < int'(a); i++) begin
      case (m)
        3'd0:    r = {r[6:0], 1'b0};
        3'd1:    r = {1'b0, r[7:1]};
        3'd2:    r = {d[7], r[7:1]};
        3'd3:    r = {r[6:0], r[7]};
        3'd4:    r = {r[0], r[7:1]};
        default: r = d;
      endcase
    end
    return r;
  endfunction

  // Present one op at a negedge; returns the cycle stamp of its accept.
  task automatic present(input logic [7:0] d, input logic [2:0] a, input logic [2:0] m, output int stamp);
    int guard;
    guard = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    in_amt   = a;
    in_mode  = m;
    #1;
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      #1;
      guard++;
    end
    stamp = cyc;
  endtask

  task automatic idle;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_results(input int n);
    int guard;
    guard = 0;
    while (got_q.size() < n && guard < 60) begin
      @(negedge clk);
      guard++;
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid_in_reset got %b want 0", out_valid); end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    checks++;
    if (out_data !== 8'h00) begin errors++; $display("FAIL reset_out_data got %h want 00", out_data); end
  endtask

  task automatic test_shift_modes;
    logic [7:0] d   [5] = '{8'b10010111, 8'b10010111, 8'b10010111, 8'b10010111, 8'b01101011};
    logic [2:0] a   [5] = '{3'd3, 3'd3, 3'd3, 3'd5, 3'd2};
    logic [2:0] m   [5] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4};
    logic [7:0] exp [5] = '{8'b10111000, 8'b00010010, 8'b11110010, 8'b11110010, 8'b11011010};
    int s [5];
    got_q.delete(); got_cyc.delete();
    for (int i = 0; i < 5; i++) present(d[i], a[i], m[i], s[i]);
    idle();
    wait_results(5);
    checks++;
    if (got_q.size() !== 5) begin errors++; $display("FAIL modes_count got %0d want 5", got_q.size()); end
    for (int i = 0; i < 5 && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp[i]) begin errors++; $display("FAIL modes_data[%0d] got %b want %b", i, got_q[i], exp[i]); end
      checks++;
      if (got_cyc[i] - s[i] !== 3) begin errors++; $display("FAIL modes_latency[%0d] got %0d want 3", i, got_cyc[i] - s[i]); end
    end
  endtask

  task automatic test_amt_zero;
    logic [2:0] a [6] = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd5};
    logic [2:0] m [6] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd6};
    int s;
    got_q.delete(); got_cyc.delete();
    for (int i = 0; i < 6; i++) present(8'hB6, a[i], m[i], s);
    idle();
    wait_results(6);
    checks++;
    if (got_q.size() !== 6) begin errors++; $display("FAIL amt0_count got %0d want 6", got_q.size()); end
    for (int i = 0; i < 6 && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== 8'hB6) begin errors++; $display("FAIL amt0_data[%0d] got %h want b6", i, got_q[i]); end
    end
  endtask

  task automatic test_backpressure;
    logic [7:0] d   [5] = '{8'h01, 8'h80, 8'h80, 8'h81, 8'h81};
    logic [2:0] a   [5] = '{3'd1, 3'd7, 3'd7, 3'd1, 3'd1};
    logic [2:0] m   [5] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4};
    logic [7:0] exp [5] = '{8'h02, 8'h01, 8'hFF, 8'h03, 8'hC0};
    int idx;
    idx = 0;
    got_q.delete(); got_cyc.delete();
    for (int t = 0; t < 14; t++) begin
      @(negedge clk);
      out_ready = !(t >= 4 && t <= 8);
      if (idx < 5) begin
        in_valid = 1'b1;
        in_data  = d[idx];
        in_amt   = a[idx];
        in_mode  = m[idx];
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (t >= 4 && t <= 8) begin
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready t=%0d got %b want 0", t, in_ready); end
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h01) begin
          errors++; $display("FAIL bp_held t=%0d got v=%b d=%h want v=1 d=01", t, out_valid, out_data);
        end
      end
      if (in_valid && in_ready) idx++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    wait_results(5);
    checks++;
    if (got_q.size() !== 5) begin errors++; $display("FAIL bp_count got %0d want 5", got_q.size()); end
    for (int i = 0; i < 5 && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp[i]) begin errors++; $display("FAIL bp_order[%0d] got %h want %h", i, got_q[i], exp[i]); end
    end
  endtask

  task automatic test_reset_midflight;
    int s;
    got_q.delete(); got_cyc.delete();
    present(8'h0F, 3'd1, 3'd0, s);
    present(8'hF0, 3'd2, 3'd1, s);
    @(negedge clk);
    in_valid = 1'b0;
    rst      = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_out_valid[%0d] got %b want 0", i, out_valid); end
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_in_ready[%0d] got %b want 1", i, in_ready); end
    end
    checks++;
    if (got_q.size() !== 0) begin errors++; $display("FAIL rst_mid_spurious got %0d want 0", got_q.size()); end
    got_q.delete(); got_cyc.delete();
    present(8'h3C, 3'd2, 3'd4, s);
    idle();
    wait_results(1);
    checks++;
    if (got_q.size() !== 1) begin
      errors++; $display("FAIL rst_mid_new_count got %0d want 1", got_q.size());
    end else begin
      checks++;
      if (got_q[0] !== 8'h0F) begin errors++; $display("FAIL rst_mid_new_data got %h want 0f", got_q[0]); end
      checks++;
      if (got_cyc[0] - s !== 3) begin errors++; $display("FAIL rst_mid_new_latency got %0d want 3", got_cyc[0] - s); end
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] exp [16];
    logic [7:0] d;
    logic [2:0] a;
    logic [2:0] m;
    int s;
    int s0;
    got_q.delete(); got_cyc.delete();
    s0 = 0;
    for (int i = 0; i < 16; i++) begin
      d = 8'($urandom_range(0, 255));
      a = 3'($urandom_range(0, 7));
      m = 3'($urandom_range(0, 7));
      exp[i] = ref_shift(d, a, m);
      present(d, a, m, s);
      if (i == 0) s0 = s;
    end
    idle();
    wait_results(16);
    checks++;
    if (got_q.size() !== 16) begin errors++; $display("FAIL b2b_count got %0d want 16", got_q.size()); end
    if (got_q.size() > 0) begin
      checks++;
      if (got_cyc[0] - s0 !== 3) begin errors++; $display("FAIL b2b_latency got %0d want 3", got_cyc[0] - s0); end
    end
    for (int i = 0; i < 16 && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp[i]) begin errors++; $display("FAIL b2b_data[%0d] got %h want %h", i, got_q[i], exp[i]); end
      checks++;
      if (got_cyc[i] !== got_cyc[0] + i) begin
        errors++; $display("FAIL b2b_cycle[%0d] got %0d want %0d", i, got_cyc[i], got_cyc[0] + i);
      end
    end
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    in_amt    = 3'd0;
    in_mode   = 3'd0;
    out_ready = 1'b1;
    test_reset();
    test_shift_modes();
    test_amt_zero();
    test_backpressure();
    test_reset_midflight();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
